// File: rtl/board_win_checker_if.sv
// Board checker bus: board contents and check request from game control,
// scan status and result fields back from the checker.
interface board_win_checker_if #(
    parameter int N = 3
);
    localparam int MEM_W  = 2 * N * N;
    localparam int LINE_W = $clog2(2 * N + 2);

    logic [MEM_W-1:0]  mem;
    logic              confirm;
    logic              busy;
    logic              done;
    logic              status_valid;
    logic [1:0]        winner;
    logic [LINE_W-1:0] win_line;
    logic              draw;
    logic              invalid;

    // Game-control side
    modport master (
        output mem, confirm,
        input  busy, done, status_valid, winner, win_line, draw, invalid
    );

    // Checker side
    modport slave (
        input  mem, confirm,
        output busy, done, status_valid, winner, win_line, draw, invalid
    );
endinterface

// File: rtl/board_win_checker.sv
// N x N tic-tac-toe result checker. A confirm in IDLE snapshots the board,
// then one line per clock is scanned: rows, columns, main and anti diagonal.
// The first winning line ends the scan, so lower-index lines take priority.
module board_win_checker #(
    parameter int N = 3
) (
    input logic                clk,
    input logic                reset,
    board_win_checker_if.slave bus
);
    localparam int MEM_W  = 2 * N * N;
    localparam int L      = 2 * N + 2;
    localparam int LINE_W = $clog2(2 * N + 2);
    localparam int PW     = $clog2(MEM_W);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state;
    logic [MEM_W-1:0]  snap;
    logic [LINE_W-1:0] idx;
    logic              busy_q;
    logic              done_q;
    logic              status_valid_q;
    logic [1:0]        winner_q;
    logic [LINE_W-1:0] win_line_q;
    logic              draw_q;
    logic              invalid_q;

    logic              mem_illegal;
    logic              snap_has_empty;
    logic              line_win;
    logic [1:0]        line_mark;

    // Cell index of the j-th cell on a line (rows, cols, main diag, anti diag)
    function automatic int unsigned line_pos(input int unsigned line, input int unsigned j);
        if (line < N)
            return line * N + j;
        else if (line < 2 * N)
            return j * N + (line - N);
        else if (line == 2 * N)
            return j * N + j;
        else
            return j * N + (N - 1 - j);
    endfunction

    // Board-wide flags: illegal cell on the live bus, empty cell in the snapshot
    always_comb begin
        mem_illegal    = 1'b0;
        snap_has_empty = 1'b0;
        for (int unsigned c = 0; c < N * N; c++) begin
            if (bus.mem[PW'(2 * c) +: 2] == 2'b11) mem_illegal = 1'b1;
            if (snap[PW'(2 * c) +: 2] == 2'b00) snap_has_empty = 1'b1;
        end
    end

    // Current line wins when every cell matches the first one and it is a mark
    always_comb begin
        line_mark = snap[PW'(2 * line_pos(32'(idx), 0)) +: 2];
        line_win  = (line_mark != 2'b00);
        for (int unsigned j = 1; j < N; j++) begin
            if (snap[PW'(2 * line_pos(32'(idx), j)) +: 2] != line_mark) line_win = 1'b0;
        end
    end

    // Control FSM with registered status/result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            snap           <= '0;
            idx            <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            status_valid_q <= 1'b0;
            winner_q       <= 2'b00;
            win_line_q     <= '0;
            draw_q         <= 1'b0;
            invalid_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.confirm) begin
                        snap           <= bus.mem;
                        winner_q       <= 2'b00;
                        win_line_q     <= '0;
                        draw_q         <= 1'b0;
                        status_valid_q <= 1'b0;
                        invalid_q      <= 1'b0;
                        if (mem_illegal) begin
                            invalid_q      <= 1'b1;
                            done_q         <= 1'b1;
                            status_valid_q <= 1'b1;
                        end else begin
                            idx    <= '0;
                            state  <= SCAN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (line_win) begin
                        winner_q       <= line_mark;
                        win_line_q     <= idx;
                        done_q         <= 1'b1;
                        status_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state          <= IDLE;
                    end else if (idx == LINE_W'(L - 1)) begin
                        draw_q         <= ~snap_has_empty;
                        done_q         <= 1'b1;
                        status_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.status_valid = status_valid_q;
    assign bus.winner       = winner_q;
    assign bus.win_line     = win_line_q;
    assign bus.draw         = draw_q;
    assign bus.invalid      = invalid_q;
endmodule
